// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall control,
// writeback-to-EX bypass of register-file read data and a saturating bubble counter.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rdata1,
    input  logic [XLEN-1:0] id_rdata2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_op,
    input  logic            id_ALUSrc,
    input  logic            id_MemRead,
    input  logic            id_MemWrite,
    input  logic            id_RegWrite,
    input  logic            id_MemtoReg,
    input  logic            id_Branch,
    input  logic [4:0]      rd_wb,
    input  logic            RegWrite_wb,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush_ex,
    input  logic            stall_ext,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_rdata1,
    output logic [XLEN-1:0] ex_rdata2,
    output logic [XLEN-1:0] ex_imm,
    output logic [3:0]      ex_alu_op,
    output logic            ex_ALUSrc,
    output logic            ex_MemRead,
    output logic            ex_MemWrite,
    output logic            ex_RegWrite,
    output logic            ex_MemtoReg,
    output logic            ex_Branch,
    output logic            stall_if_id,
    output logic [15:0]     bubble_count
);

    logic            load_use_s;
    logic            bubble_s;
    logic            ctrl_en_s;
    logic [XLEN-1:0] fwd_rdata1_s;
    logic [XLEN-1:0] fwd_rdata2_s;

    // Writeback value overrides the stale register-file read; x0 is never bypassed.
    function automatic logic [XLEN-1:0] wb_bypass(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rdata,
        input logic            wb_en,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_val
    );
        logic [XLEN-1:0] result;
        if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            result = wb_val;
        end else begin
            result = rdata;
        end
        return result;
    endfunction

    // Hazard detection, stall request and bypass selection.
    always_comb begin
        load_use_s   = 1'b0;
        bubble_s     = 1'b0;
        ctrl_en_s    = 1'b0;
        stall_if_id  = 1'b0;
        fwd_rdata1_s = {XLEN{1'b0}};
        fwd_rdata2_s = {XLEN{1'b0}};

        load_use_s = ex_valid && ex_MemRead && (ex_rd != 5'd0) && id_valid &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));
        // A flush already squashes the ID instruction, so a hazard alone must not hold IF/ID.
        stall_if_id  = stall_ext || (load_use_s && !flush_ex);
        bubble_s     = !stall_ext && (flush_ex || load_use_s);
        ctrl_en_s    = id_valid;
        fwd_rdata1_s = wb_bypass(id_rs1, id_rdata1, RegWrite_wb, rd_wb, wb_data);
        fwd_rdata2_s = wb_bypass(id_rs2, id_rdata2, RegWrite_wb, rd_wb, wb_data);
    end

    // Pipeline register update: stall holds, bubble clears, otherwise capture ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= {XLEN{1'b0}};
            ex_rs1       <= 5'd0;
            ex_rs2       <= 5'd0;
            ex_rd        <= 5'd0;
            ex_rdata1    <= {XLEN{1'b0}};
            ex_rdata2    <= {XLEN{1'b0}};
            ex_imm       <= {XLEN{1'b0}};
            ex_alu_op    <= 4'd0;
            ex_ALUSrc    <= 1'b0;
            ex_MemRead   <= 1'b0;
            ex_MemWrite  <= 1'b0;
            ex_RegWrite  <= 1'b0;
            ex_MemtoReg  <= 1'b0;
            ex_Branch    <= 1'b0;
            bubble_count <= 16'd0;
        end else if (stall_ext) begin
            ex_valid     <= ex_valid;
            bubble_count <= bubble_count;
        end else if (bubble_s) begin
            ex_valid     <= 1'b0;
            ex_pc        <= {XLEN{1'b0}};
            ex_rs1       <= 5'd0;
            ex_rs2       <= 5'd0;
            ex_rd        <= 5'd0;
            ex_rdata1    <= {XLEN{1'b0}};
            ex_rdata2    <= {XLEN{1'b0}};
            ex_imm       <= {XLEN{1'b0}};
            ex_alu_op    <= 4'd0;
            ex_ALUSrc    <= 1'b0;
            ex_MemRead   <= 1'b0;
            ex_MemWrite  <= 1'b0;
            ex_RegWrite  <= 1'b0;
            ex_MemtoReg  <= 1'b0;
            ex_Branch    <= 1'b0;
            if (bubble_count != 16'hFFFF) begin
                bubble_count <= bubble_count + 16'd1;
            end else begin
                bubble_count <= bubble_count;
            end
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
            ex_rdata1    <= fwd_rdata1_s;
            ex_rdata2    <= fwd_rdata2_s;
            ex_imm       <= id_imm;
            ex_alu_op    <= id_alu_op;
            ex_ALUSrc    <= id_ALUSrc   && ctrl_en_s;
            ex_MemRead   <= id_MemRead  && ctrl_en_s;
            ex_MemWrite  <= id_MemWrite && ctrl_en_s;
            ex_RegWrite  <= id_RegWrite && ctrl_en_s;
            ex_MemtoReg  <= id_MemtoReg && ctrl_en_s;
            ex_Branch    <= id_Branch   && ctrl_en_s;
            bubble_count <= bubble_count;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: normal flow, load-use, bypass,
// priority, flush+hazard, counter saturation and asynchronous reset.
module tb_id_ex_stage;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0] id_rdata1, id_rdata2, id_imm;
    logic [3:0]      id_alu_op;
    logic            id_ALUSrc, id_MemRead, id_MemWrite, id_RegWrite, id_MemtoReg, id_Branch;
    logic [4:0]      rd_wb;
    logic            RegWrite_wb;
    logic [XLEN-1:0] wb_data;
    logic            flush_ex, stall_ext;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [XLEN-1:0] ex_rdata1, ex_rdata2, ex_imm;
    logic [3:0]      ex_alu_op;
    logic            ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg, ex_Branch;
    logic            stall_if_id;
    logic [15:0]     bubble_count;

    int tests_run;
    int tests_failed;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_alu_op(id_alu_op),
        .id_ALUSrc(id_ALUSrc), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_Branch(id_Branch),
        .rd_wb(rd_wb), .RegWrite_wb(RegWrite_wb), .wb_data(wb_data),
        .flush_ex(flush_ex), .stall_ext(stall_ext),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_alu_op(ex_alu_op),
        .ex_ALUSrc(ex_ALUSrc), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch),
        .stall_if_id(stall_if_id), .bubble_count(bubble_count)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        id_valid = 1'b0; id_pc = 32'h0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
        id_rdata1 = 32'h0; id_rdata2 = 32'h0; id_imm = 32'h0; id_alu_op = 4'd0;
        id_ALUSrc = 1'b0; id_MemRead = 1'b0; id_MemWrite = 1'b0; id_RegWrite = 1'b0;
        id_MemtoReg = 1'b0; id_Branch = 1'b0;
        rd_wb = 5'd0; RegWrite_wb = 1'b0; wb_data = 32'h0;
        flush_ex = 1'b0; stall_ext = 1'b0;

        // Reset state
        #3;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_bubble", {16'd0, bubble_count}, 32'd0);
        chk("rst_stall", {31'd0, stall_if_id}, 32'd0);
        #4 rst_n = 1'b1;

        // Normal flow
        id_valid = 1'b1; id_pc = 32'h100; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd5;
        id_RegWrite = 1'b1; id_rdata1 = 32'h11; id_imm = 32'h44; id_alu_op = 4'd3; id_ALUSrc = 1'b1;
        tick();
        chk("norm_valid", {31'd0, ex_valid}, 32'd1);
        chk("norm_rd", {27'd0, ex_rd}, 32'd5);
        chk("norm_rdata1", ex_rdata1, 32'h11);
        chk("norm_pc", ex_pc, 32'h100);
        chk("norm_imm", ex_imm, 32'h44);
        chk("norm_aluop", {28'd0, ex_alu_op}, 32'd3);
        chk("norm_alusrc", {31'd0, ex_ALUSrc}, 32'd1);
        chk("norm_regwrite", {31'd0, ex_RegWrite}, 32'd1);
        chk("norm_bubble", {16'd0, bubble_count}, 32'd0);

        // Load-use: lw x3 into EX, then add reading x3
        id_pc = 32'h104; id_MemRead = 1'b1; id_MemtoReg = 1'b1; id_rd = 5'd3; id_ALUSrc = 1'b0;
        tick();
        chk("lw_memread", {31'd0, ex_MemRead}, 32'd1);
        id_pc = 32'h108; id_MemRead = 1'b0; id_MemtoReg = 1'b0; id_rs1 = 5'd3; id_rs2 = 5'd4; id_rd = 5'd6;
        #1;
        chk("lu_stall", {31'd0, stall_if_id}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_rd", {27'd0, ex_rd}, 32'd0);
        chk("lu_bubble_memread", {31'd0, ex_MemRead}, 32'd0);
        chk("lu_bubble_cnt", {16'd0, bubble_count}, 32'd1);
        chk("lu_stall_clear", {31'd0, stall_if_id}, 32'd0);
        tick();
        chk("lu_cap_rs1", {27'd0, ex_rs1}, 32'd3);
        chk("lu_cap_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_cap_rd", {27'd0, ex_rd}, 32'd6);
        chk("lu_cap_cnt", {16'd0, bubble_count}, 32'd1);

        // Load to x0 never stalls
        id_MemRead = 1'b1; id_rd = 5'd0; id_rs1 = 5'd1; id_rs2 = 5'd2;
        tick();
        id_MemRead = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd8;
        #1;
        chk("x0_stall", {31'd0, stall_if_id}, 32'd0);
        tick();
        chk("x0_valid", {31'd0, ex_valid}, 32'd1);
        chk("x0_rd", {27'd0, ex_rd}, 32'd8);
        chk("x0_cnt", {16'd0, bubble_count}, 32'd1);

        // WB bypass
        RegWrite_wb = 1'b1; rd_wb = 5'd7; wb_data = 32'hABCD;
        id_rs1 = 5'd1; id_rdata1 = 32'h22; id_rs2 = 5'd7; id_rdata2 = 32'h1;
        tick();
        chk("byp_rdata2", ex_rdata2, 32'hABCD);
        chk("byp_rdata1_nomatch", ex_rdata1, 32'h22);
        rd_wb = 5'd0; id_rs2 = 5'd0;
        tick();
        chk("byp_x0_rdata2", ex_rdata2, 32'h1);
        rd_wb = 5'd1; RegWrite_wb = 1'b0;
        tick();
        chk("byp_nowe_rdata1", ex_rdata1, 32'h22);

        // id_valid=0 capture: controls gated, fields captured, no bubble
        id_valid = 1'b0; id_RegWrite = 1'b1; id_rd = 5'd9;
        tick();
        chk("inv_valid", {31'd0, ex_valid}, 32'd0);
        chk("inv_regwrite", {31'd0, ex_RegWrite}, 32'd0);
        chk("inv_rd", {27'd0, ex_rd}, 32'd9);
        chk("inv_cnt", {16'd0, bubble_count}, 32'd1);

        // Priority: stall_ext over flush for 3 cycles
        id_valid = 1'b1; id_rd = 5'd10; id_pc = 32'h200;
        stall_ext = 1'b1; flush_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("prio_hold_rd", {27'd0, ex_rd}, 32'd9);
            chk("prio_stall", {31'd0, stall_if_id}, 32'd1);
        end
        chk("prio_hold_cnt", {16'd0, bubble_count}, 32'd1);
        stall_ext = 1'b0;
        tick();
        chk("prio_flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("prio_flush_cnt", {16'd0, bubble_count}, 32'd2);

        // Flush together with load-use
        flush_ex = 1'b0; id_MemRead = 1'b1; id_rd = 5'd3;
        tick();
        id_MemRead = 1'b0; id_rs1 = 5'd3; id_rd = 5'd11; flush_ex = 1'b1; stall_ext = 1'b1;
        #1;
        chk("fl_lu_stallext", {31'd0, stall_if_id}, 32'd1);
        stall_ext = 1'b0;
        #1;
        chk("fl_lu_stall", {31'd0, stall_if_id}, 32'd0);
        tick();
        chk("fl_lu_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_lu_cnt", {16'd0, bubble_count}, 32'd3);

        // Saturation: flush until the counter reaches 0xFFFF, then once more
        repeat (65532) @(posedge clk);
        #1;
        chk("sat_reach", {16'd0, bubble_count}, 32'h0000FFFF);
        tick();
        chk("sat_hold", {16'd0, bubble_count}, 32'h0000FFFF);

        // Asynchronous reset mid-cycle
        flush_ex = 1'b0;
        tick();
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        #2 rst_n = 1'b0; stall_ext = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("async_rst_cnt", {16'd0, bubble_count}, 32'd0);
        chk("async_rst_stall", {31'd0, stall_if_id}, 32'd1);
        #1 rst_n = 1'b1; stall_ext = 1'b0;
        tick();
        chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);
        chk("post_rst_rd", {27'd0, ex_rd}, 32'd11);
        chk("post_rst_cnt", {16'd0, bubble_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width of register operands, immediate and PC.
REQ-002 One clock; reset is asynchronous and active-low: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-003 id_valid in 1 | id_pc in XLEN | id_rs1, id_rs2, id_rd in 5 each | id_rdata1, id_rdata2 in XLEN (register-file reads) | id_imm in XLEN | id_alu_op in 4.
REQ-004 Decode control inputs, 1 bit each: id_ALUSrc, id_MemRead, id_MemWrite, id_RegWrite, id_MemtoReg, id_Branch.
REQ-005 Writeback inputs: rd_wb in 5 | RegWrite_wb in 1 | wb_data in XLEN (value being written to the register file this cycle).
REQ-006 Control inputs: flush_ex in 1 (branch taken, squash the ID instruction) | stall_ext in 1 (downstream busy, freeze the stage).
REQ-007 Registered outputs, each mirroring its id_* input: ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_alu_op, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg, ex_Branch.
REQ-008 stall_if_id out 1, combinational; holds the PC and the IF/ID register.
REQ-009 bubble_count out 16, registered; count of bubbles inserted.

Function
REQ-010 Update priority at each rising clk edge: stall_ext > flush_ex > load-use > normal capture.
REQ-011 stall_ext=1: every ex_* register and bubble_count hold their value.
REQ-012 Load-use hazard (comb) = ex_valid & ex_MemRead & (ex_rd!=0) & id_valid & ((ex_rd==id_rs1) | (ex_rd==id_rs2)).
REQ-013 stall_if_id = stall_ext | (load_use & ~flush_ex).
REQ-014 A bubble is inserted when stall_ext=0 and either flush_ex=1 or the load-use hazard is present.
REQ-015 Bubble contents: ex_valid=0; ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_MemtoReg, ex_ALUSrc all 0; ex_rd=0; the other ex_* fields are loaded to 0.
REQ-016 Each bubble increments bubble_count by 1; it saturates at 16'hFFFF and never wraps.
REQ-017 Normal capture (stall_ext=0, flush_ex=0, no hazard):
  - every ex_* register takes its id_* value;
  - ex_valid=id_valid;
  - when id_valid=0, all control outputs load 0.
REQ-018 WB bypass on capture: if RegWrite_wb & (rd_wb!=0) & (rd_wb==id_rs1), ex_rdata1=wb_data, else id_rdata1; same rule for rs2 into ex_rdata2.
REQ-019 No bypass when the matching source register is x0; ex_rdata is then id_rdata unchanged.
REQ-020 A load-use hazard produces exactly one bubble. On the next cycle the load has left EX, the hazard clears and the held ID instruction is captured.
REQ-021 Latency: an instruction accepted in ID appears on ex_* exactly one cycle later, absent stall and bubble.
REQ-022 No instruction is lost or duplicated:
  - while stall_if_id=1 the upstream stage holds id_* stable;
  - the stage relies on that stability.
REQ-023 flush_ex together with a load-use hazard: the instruction is squashed, stall_if_id=0 (unless stall_ext=1), and only one bubble is counted.

Reset
REQ-024 rst_n=0 immediately (asynchronously) forces every ex_* register and bubble_count to 0; ex_valid=0.
REQ-025 Reset mid-stall discards the held state; the first edge after rst_n rises captures id_* per REQ-010.
REQ-026 stall_if_id is combinational; with ex_valid=0 under reset it equals stall_ext.

Verification
REQ-027 Normal flow: id_valid=1, id_rd=5, id_RegWrite=1, id_rdata1=0x11 -> next cycle ex_valid=1, ex_rd=5, ex_rdata1=0x11; bubble_count=0.
REQ-028 Load-use: EX holds lw x3 (ex_MemRead=1, ex_rd=3); ID has add with rs1=3 -> stall_if_id=1; next cycle ex_valid=0 and bubble_count=1; the cycle after, ex_rs1=3 and ex_valid=1.
REQ-029 Load to x0: ex_MemRead=1, ex_rd=0, id_rs1=0 -> stall_if_id=0; no bubble.
REQ-030 WB bypass: RegWrite_wb=1, rd_wb=7, wb_data=0xABCD, id_rs2=7, id_rdata2=0x1 -> ex_rdata2=0xABCD. Repeat with rd_wb=0 and id_rs2=0 -> ex_rdata2=id_rdata2.
REQ-031 Priority: stall_ext=1 and flush_ex=1 for 3 cycles -> ex_* unchanged, stall_if_id=1. Then stall_ext=0 with flush_ex=1 -> bubble, bubble_count increments by 1.
REQ-032 Saturation and reset: preload 0xFFFF bubbles, then flush again -> count stays 0xFFFF. Drop rst_n mid-cycle -> ex_valid and bubble_count read 0 before the next clk edge.
